// File: rtl/ex01.sv
// ex01: clocked 4-input Boolean function evaluator.
// The inputs a..d pass through an optional per-bit synchronizer, are combined
// into a 4-bit index {d,c,b,a} and looked up in TRUTH_TABLE; the result is
// registered on x. Every change of x raises a one-cycle x_chg pulse and bumps
// a saturating change counter.
//
// Ports:
//   clk      system clock, rising-edge active
//   rst_n    asynchronous active-low reset
//   a,b,c,d  function inputs (index bits 0..3), may be asynchronous to clk
//   x        registered function result
//   x_chg    one-cycle pulse in the cycle x shows a new value
//   chg_cnt  saturating count of x changes since reset
module ex01 #(
  parameter logic [15:0] TRUTH_TABLE = 16'h8F88,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a,
  input  logic             b,
  input  logic             c,
  input  logic             d,
  output logic             x,
  output logic             x_chg,
  output logic [CNT_W-1:0] chg_cnt
);

  logic [3:0] idx;
  logic       next_x;

  generate
    if (SYNC_STAGES == 0) begin : g_direct
      assign idx = {d, c, b, a};
    end else begin : g_sync
      // All four bits move through the stages together so a multi-bit input
      // change reaches the lookup in a single cycle.
      logic [3:0] stage [SYNC_STAGES];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
            stage[i] <= '0;
          end
        end else begin
          stage[0] <= {d, c, b, a};
          for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
            stage[i] <= stage[i-1];
          end
        end
      end

      assign idx = stage[SYNC_STAGES-1];
    end
  endgenerate

  always_comb begin
    next_x = TRUTH_TABLE[idx];
  end

  // The counter advances on the same edge that raises x_chg, so chg_cnt
  // already includes a change during the cycle its pulse is visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x       <= 1'b0;
      x_chg   <= 1'b0;
      chg_cnt <= '0;
    end else begin
      x     <= next_x;
      x_chg <= (next_x != x);
      if ((next_x != x) && (chg_cnt != '1)) begin
        chg_cnt <= chg_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ex01.sv
// Directed testbench for ex01: reset state, full input sweep, latency,
// non-changing input, counter saturation (CNT_W=2 instance) and mid-operation
// asynchronous reset.
module tb_ex01;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       a, b, c, d;
  logic       x, x_chg;
  logic [7:0] chg_cnt;
  logic       sx, sx_chg;
  logic [1:0] s_cnt;

  int n_total = 0;
  int n_pass  = 0;

  always #2 clk = ~clk;

  ex01 u_dut (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .c(c), .d(d),
    .x(x), .x_chg(x_chg), .chg_cnt(chg_cnt)
  );

  ex01 #(.CNT_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .c(c), .d(d),
    .x(sx), .x_chg(sx_chg), .chg_cnt(s_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp)
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    else
      n_pass++;
  endtask

  task automatic set_idx(input logic [3:0] v);
    {d, c, b, a} = v;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    cycles(2);
    rst_n = 1'b1;
  endtask

  // Independent reference: x = (a & b) | (~c & d)
  function automatic logic model(input logic [3:0] v);
    return (v[0] & v[1]) | (~v[2] & v[3]);
  endfunction

  logic [1:0] sat_exp [5];

  initial begin
    sat_exp[0] = 2'd1; sat_exp[1] = 2'd2; sat_exp[2] = 2'd3;
    sat_exp[3] = 2'd3; sat_exp[4] = 2'd3;

    // Reset check
    rst_n = 1'b0;
    set_idx(4'd0);
    cycles(3);
    chk("rst_x", x, 0);
    chk("rst_x_chg", x_chg, 0);
    chk("rst_cnt", chg_cnt, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("post_rst_x", x, 0);
    end
    chk("post_rst_cnt", chg_cnt, 0);

    // Full sweep: hold each index 10 cycles, then wrap back to 0
    for (int i = 0; i < 16; i++) begin
      set_idx(4'(i));
      cycles(10);
      chk($sformatf("sweep_x_idx%0d", i), x, model(4'(i)));
    end
    set_idx(4'd0);
    cycles(10);
    chk("sweep_x_wrap", x, 0);
    chk("sweep_cnt", chg_cnt, 6);

    // Latency: idx 0 -> 3 (a=b=1), x rises on 3rd edge
    do_reset();
    set_idx(4'd0);
    cycles(4);
    a = 1'b1; b = 1'b1;
    @(negedge clk); chk("lat_e1_x", x, 0);
    @(negedge clk); chk("lat_e2_x", x, 0);
    @(negedge clk); chk("lat_e3_x", x, 1); chk("lat_e3_chg", x_chg, 1);
    @(negedge clk); chk("lat_e4_x", x, 1); chk("lat_e4_chg", x_chg, 0);
    chk("lat_cnt", chg_cnt, 1);

    // Mid-operation reset while x=1
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_x", x, 0);
    chk("mid_rst_cnt", chg_cnt, 0);
    chk("mid_rst_chg", x_chg, 0);
    #1 rst_n = 1'b1;
    @(negedge clk); chk("mid_e1_x", x, 0); chk("mid_e1_chg", x_chg, 0);
    @(negedge clk); chk("mid_e2_x", x, 0);
    @(negedge clk); chk("mid_e3_x", x, 1); chk("mid_e3_chg", x_chg, 1);
    chk("mid_e3_cnt", chg_cnt, 1);

    // Non-changing input: idx 8 -> 9
    do_reset();
    set_idx(4'd8);
    cycles(6);
    chk("nc_x8", x, 1);
    chk("nc_cnt8", chg_cnt, 1);
    set_idx(4'd9);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("nc_chg", x_chg, 0);
      chk("nc_x9", x, 1);
    end
    chk("nc_cnt9", chg_cnt, 1);

    // Saturation: CNT_W=2 instance, 5 changes via idx 2 <-> 3
    do_reset();
    set_idx(4'd2);
    cycles(4);
    for (int k = 0; k < 5; k++) begin
      a = ~a;
      cycles(5);
      chk($sformatf("sat_cnt%0d", k), s_cnt, sat_exp[k]);
      chk($sformatf("wide_cnt%0d", k), chg_cnt, k + 1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
